// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared constants and event type for the key event encoder
package key_pkg;
  localparam int KEY_CNT    = 16;
  localparam int KEY_CODE_W = 4;

  // One queued event: press flag above the 4-bit key code.
  typedef struct packed {
    logic                  press;
    logic [KEY_CODE_W-1:0] code;
  } key_evt_t;

  localparam int KEY_EVT_W = $bits(key_evt_t);
endpackage

// File: rtl/key_event_encoder_if.sv
// rtl/key_event_encoder_if.sv - valid/ready event stream between encoder and consumer
// Signals: evt_valid, evt_ready, evt_code[3:0], evt_press.
// master = event source (encoder), slave = consumer.
interface key_event_encoder_if;
  import key_pkg::*;

  logic                  evt_valid;
  logic                  evt_ready;
  logic [KEY_CODE_W-1:0] evt_code;
  logic                  evt_press;

  modport master (output evt_valid, output evt_code, output evt_press, input evt_ready);
  modport slave  (input evt_valid, input evt_code, input evt_press, output evt_ready);
endinterface

// File: rtl/key_evt_fifo.sv
// rtl/key_evt_fifo.sv - synchronous show-ahead FIFO with occupancy count
// Ports: clk, rst_n (async low), push_i/data_i/full_o write side,
//        pop_i/data_o/empty_o read side; data_o shows the head entry.
module key_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_en, pop_en;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

  // Both gates look at the count as it stood at the start of the cycle,
  // so a pop never makes room for a push in the same cycle.
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  // Head is forced to zero when empty so the outputs read idle.
  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, push_en} - {{AW{1'b0}}, pop_en};
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/key_event_encoder.sv
// rtl/key_event_encoder.sv - turns the keypad level bitmap into press/release events
// Ports: clk, rst_n (async low), keys[16:1] level bitmap,
//        evt (master: evt_valid/evt_ready/evt_code/evt_press),
//        busy (unreported differences pending), key_any (a key is reported held).
module key_event_encoder
  import key_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [KEY_CNT:1]         keys,
  key_event_encoder_if.master      evt,
  output logic                     busy,
  output logic                     key_any
);
  logic [KEY_CNT:1]      keys_r_q;
  logic [KEY_CNT:1]      prev_q, prev_d;
  logic [KEY_CNT:1]      diff;
  logic [KEY_CNT:1]      low_bit;
  logic [KEY_CODE_W-1:0] sel_code;
  logic                  fifo_full, fifo_empty, push_ok;
  key_evt_t              push_evt, head_evt;

  assign diff    = keys_r_q ^ prev_q;
  assign busy    = |diff;
  assign key_any = |prev_q;

  // Isolate the lowest set bit: x & -x.
  assign low_bit = diff & (~diff + KEY_CNT'(1));

  // Lowest-index changed key wins; scanning downward leaves the lowest last.
  always_comb begin
    sel_code = '0;
    for (int i = KEY_CNT; i >= 1; i--) begin
      if (diff[i]) sel_code = KEY_CODE_W'(i - 1);
    end
  end

  // A stalled encoder leaves prev untouched, so toggles that cancel out
  // while the FIFO is full never produce an event.
  assign push_ok = busy && !fifo_full;

  assign push_evt.press = |(keys_r_q & low_bit);
  assign push_evt.code  = sel_code;

  assign prev_d = push_ok ? (prev_q ^ low_bit) : prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_r_q <= '0;
      prev_q   <= '0;
    end else begin
      keys_r_q <= keys;
      prev_q   <= prev_d;
    end
  end

  key_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_EVT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_ok),
    .data_i  (push_evt),
    .full_o  (fifo_full),
    .pop_i   (evt.evt_ready),
    .data_o  (head_evt),
    .empty_o (fifo_empty)
  );

  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_code  = head_evt.code;
  assign evt.evt_press = head_evt.press;
endmodule

// File: tb/tb_key_event_encoder.sv
// tb/tb_key_event_encoder.sv - self-checking bench for key_event_encoder
module tb_key_event_encoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:1] keys;
  logic        busy, key_any;

  key_event_encoder_if evt_if ();

  key_event_encoder #(.FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .keys    (keys),
    .evt     (evt_if),
    .busy    (busy),
    .key_any (key_any)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [16:1] keys;
    logic        ready;
    logic        valid;
    logic [3:0]  code;
    logic        press;
    logic        busy;
    logic        any;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] got_q[$];
  logic [4:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected events: one per set bit of mask, ascending key order.
  task automatic build_exp(input logic [16:1] mask, input logic press);
    logic [3:0] c;
    exp_q.delete();
    for (int i = 1; i <= 16; i++) begin
      if (mask[i]) begin
        c = 4'(i - 1);
        exp_q.push_back({press, c});
      end
    end
  endtask

  // Hold ready high and record every head event until idle for 3 samples.
  task automatic drain();
    int idle = 0;
    int cyc  = 0;
    got_q.delete();
    evt_if.evt_ready = 1'b1;
    while (idle < 3 && cyc < 60) begin
      if (evt_if.evt_valid) got_q.push_back({evt_if.evt_press, evt_if.evt_code});
      if (!evt_if.evt_valid && !busy) idle++;
      else idle = 0;
      tick();
      cyc++;
    end
    evt_if.evt_ready = 1'b0;
    chk("drain_timeout", 32'(cyc < 60), 32'd1);
  endtask

  task automatic cmp_lists(input string name);
    chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_evt%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic chk_out(input string name, input logic v, input logic [3:0] c,
                         input logic p, input logic b, input logic a);
    chk({name, "_valid"}, 32'(evt_if.evt_valid), 32'(v));
    chk({name, "_busy"},  32'(busy),             32'(b));
    chk({name, "_any"},   32'(key_any),          32'(a));
    if (v) begin
      chk({name, "_code"},  32'(evt_if.evt_code),  32'(c));
      chk({name, "_press"}, 32'(evt_if.evt_press), 32'(p));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    keys  = '0;
    evt_if.evt_ready = 1'b0;

    //            keys      rdy  vld  code  prs  busy any
    vecs.push_back('{16'h0000, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{16'h0010, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0});
    vecs.push_back('{16'h0010, 1'b0, 1'b1, 4'd4,  1'b1, 1'b0, 1'b1});
    vecs.push_back('{16'h0010, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1});
    vecs.push_back('{16'h0000, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1});
    vecs.push_back('{16'h0000, 1'b0, 1'b1, 4'd4,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{16'h0000, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{16'h8104, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0});
    vecs.push_back('{16'h8104, 1'b1, 1'b1, 4'd2,  1'b1, 1'b1, 1'b1});
    vecs.push_back('{16'h8104, 1'b1, 1'b1, 4'd8,  1'b1, 1'b1, 1'b1});
    vecs.push_back('{16'h8104, 1'b1, 1'b1, 4'd15, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{16'h8104, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1});
    vecs.push_back('{16'h0000, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1});
    vecs.push_back('{16'h0000, 1'b1, 1'b1, 4'd2,  1'b0, 1'b1, 1'b1});
    vecs.push_back('{16'h0000, 1'b1, 1'b1, 4'd8,  1'b0, 1'b1, 1'b1});
    vecs.push_back('{16'h0000, 1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{16'h0000, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0});

    tick();
    tick();
    chk_out("reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("reset_code",  32'(evt_if.evt_code),  32'd0);
    chk("reset_press", 32'(evt_if.evt_press), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      keys = vecs[i].keys;
      evt_if.evt_ready = vecs[i].ready;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].valid, vecs[i].code,
              vecs[i].press, vecs[i].busy, vecs[i].any);
    end
    evt_if.evt_ready = 1'b0;

    // Five presses, FIFO holds four, code 9 pending. One-cycle ready pulse:
    // the pop happens but the push of code 9 waits for the next edge.
    keys = 16'h022B;
    repeat (6) tick();
    chk_out("full_a", 1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
    chk_out("pulse_pop", 1'b1, 4'd1, 1'b1, 1'b1, 1'b1);
    tick();
    chk_out("pulse_push", 1'b1, 4'd1, 1'b1, 1'b0, 1'b1);
    drain();
    build_exp(16'h022A, 1'b1);
    cmp_lists("pulse_drain");

    // Stall, then key 7 pressed and released while full: no code 6.
    keys = 16'h022B | 16'h1494;
    repeat (6) tick();
    chk_out("stall_b", 1'b1, 4'd2, 1'b1, 1'b1, 1'b1);
    keys = 16'h022B | 16'h1494 | 16'h0040;
    repeat (3) tick();
    keys = 16'h022B | 16'h1494;
    repeat (3) tick();
    drain();
    build_exp(16'h1494, 1'b1);
    cmp_lists("key7_drain");

    // Release everything, then six presses against a stalled depth-4 FIFO.
    keys = 16'h0000;
    drain();
    build_exp(16'h16BF, 1'b0);
    cmp_lists("release_all");
    keys = 16'h0A2B;
    repeat (8) tick();
    chk_out("six_stall", 1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
    drain();
    build_exp(16'h0A2B, 1'b1);
    cmp_lists("six_drain");

    // Leave key 2 held, queue a key 9 press, then reset mid-stream.
    keys = 16'h0002;
    drain();
    build_exp(16'h0A29, 1'b0);
    cmp_lists("to_key2");
    keys = 16'h0102;
    repeat (3) tick();
    chk_out("pre_reset", 1'b1, 4'd8, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("async_reset_code",  32'(evt_if.evt_code),  32'd0);
    chk("async_reset_press", 32'(evt_if.evt_press), 32'd0);
    keys = 16'h0002;
    tick();
    rst_n = 1'b1;
    drain();
    build_exp(16'h0002, 1'b1);
    cmp_lists("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/key_event_encoder.md
# key_event_encoder

Converts the 16-bit level bitmap `keys[16:1]` produced by the matrix-keypad scanner into a stream of discrete press/release events, each carrying a 4-bit key code. Events are buffered in a small FIFO and offered to the consumer (CPU input port / instruction loader) over a valid/ready handshake. The block sits directly downstream of the keypad scanner, in the same 50 MHz clock domain.

## Interface
Parameters:
- `FIFO_DEPTH`, 4, event buffer depth; power of two, ≥2.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `keys`  in  16 (`[16:1]`)  level bitmap; 1 = key held. Bit n = key n.
- `evt_valid`  out  1  FIFO head holds an event.
- `evt_ready`  in  1  consumer accepts the head event.
- `evt_code`  out  4  key code of the head event = key index − 1 (key 1 → 0, key 16 → 15).
- `evt_press`  out  1  1 = press (0→1 transition), 0 = release (1→0).
- `busy`  out  1  unreported bitmap differences remain (`keys_r ^ prev` ≠ 0).
- `key_any`  out  1  OR of `prev`, i.e. at least one key is reported as held.

## Operation
- `keys` registered into `keys_r` every cycle.
- `prev[16:1]`: last reported state per key; reset 0.
- `diff = keys_r ^ prev`. Each cycle with `diff ≠ 0` and FIFO not full: select the lowest set bit n, push {press = keys_r[n], code = n−1}, flip `prev[n]`. At most one push per cycle.
- FIFO full: no push, `prev` unchanged. Nothing is dropped; the encoder stalls until space frees up. A key that toggles and returns to its previous level while stalled produces no event (net-change semantics).
- Pop on `evt_valid && evt_ready`. `evt_code`/`evt_press` are stable while `evt_valid` is high and not popped.
- Push into a full FIFO is blocked even if a pop occurs in the same cycle (fullness is evaluated at the start of the cycle). Push and pop in the same cycle with FIFO not full: both happen, and the count is unchanged.
- No bypass: an event pushed into an empty FIFO becomes visible on the following cycle.
- Pointer wrap is modulo `FIFO_DEPTH`. Full/empty are determined by an occupancy count of width clog2(DEPTH)+1.

## Timing
- Reset (async assert, sync release): `keys_r`=0, `prev`=0, FIFO empty, `evt_valid`=0, `evt_code`=0, `evt_press`=0, `busy`=0, `key_any`=0.
- `keys` changes before edge E0 → `keys_r` updates at E0 → push at E1 → `evt_valid`=1 after E1. Two-cycle latency with an empty FIFO.
- k simultaneous changes are reported in ascending key order on k consecutive cycles, FIFO permitting.
- `busy` and `key_any` are combinational from registers.
- Reset mid-operation: pending FIFO contents and `prev` are discarded. After release, every held key is re-reported as a press, because `prev`=0.

## Structure
- Shared package `key_pkg`: `KEY_CNT`=16, `KEY_CODE_W`=4, and a packed event type {press, code[3:0]} of 5 bits.
- Sub-module `key_evt_fifo`: synchronous FIFO with show-ahead output, parameterised by depth and width, using the same `clk`/`rst_n`.
- The top level contains the `keys_r`/`prev` registers, the lowest-set-bit priority encoder, and the push control.

## Test plan
- Reset with `keys`=16'h0000, then set key 5 (bit 5) high → after 2 cycles `evt_valid`=1, `evt_code`=4, `evt_press`=1. Pop it, drop key 5 → event code 4, press 0.
- Keys 3, 9 and 16 pressed in the same cycle with `evt_ready`=1 → three events on consecutive cycles with codes 2, 8, 15, all press; `busy` then falls to 0.
- `evt_ready`=0, 6 keys pressed at once, DEPTH=4 → FIFO fills with codes in ascending order and `busy` stays 1. Raise `evt_ready` → all 6 events delivered in order with no loss or duplication.
- FIFO full with one diff bit pending, apply a single-cycle `evt_ready` pulse → the pop happens but no push occurs that cycle; the push lands on the next cycle.
- Stalled FIFO: key 7 pressed then released before space frees → no code-6 event is ever emitted.
- Key 2 held, assert `rst_n`=0 mid-stream → all outputs return to reset values immediately. After release, a code-1 press event is re-emitted.
